// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator processor control unit.
// The opcode values here are the single source for the generated opcodes.h.
package cpu_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_BNE   = 3'b100,
    OP_XOR   = 3'b101,
    OP_JMP   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_XOR  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    FETCH_ADDR,
    FETCH_RD,
    DECODE,
    EXEC_RD,
    EXEC_WR,
    HALT
  } state_t;

  // ALU function applied while a memory operand is being read into ACC
  function automatic alu_op_t alu_for(opcode_t op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/handshake bundle between the sequencer and the datapath.
// The sequencer is the master: it reads status and drives every strobe.
interface cpu_sequencer_if #(
  parameter int OP_W = 3
);

  logic            run;
  logic [OP_W-1:0] op;
  logic            z_flag;
  logic            mem_ready;

  logic            PC_bus;
  logic            load_PC;
  logic            INC_PC;
  logic            load_IR;
  logic            Addr_bus;
  logic            load_MAR;
  logic            MDR_bus;
  logic            load_MDR;
  logic            CS;
  logic            R_NW;
  logic            ACC_bus;
  logic            load_ACC;
  logic [1:0]      ALU_op;
  logic            halted;

  modport master (
    input  run, op, z_flag, mem_ready,
    output PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR,
           MDR_bus, load_MDR, CS, R_NW, ACC_bus, load_ACC, ALU_op, halted
  );

  modport slave (
    output run, op, z_flag, mem_ready,
    input  PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR,
           MDR_bus, load_MDR, CS, R_NW, ACC_bus, load_ACC, ALU_op, halted
  );

endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit accumulator processor.
// Outputs are decoded combinationally from state and the live inputs, and are
// forced to the idle pattern (R_NW=1, everything else 0) while n_reset is low
// so that no bus drive or memory write survives the reset edge.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic             clock,
  input  logic             n_reset,
  cpu_sequencer_if.master  bus
);

  // The opcode encodings are fixed at three bits and need an address field beside them
  if (OP_W != OPCODE_W || WORD_W <= OP_W) begin : g_bad_width
    $error("cpu_sequencer: OP_W must equal %0d and WORD_W must exceed OP_W", OPCODE_W);
  end

  state_t  state;
  state_t  next_state;
  opcode_t opc;

  assign opc = opcode_t'(bus.op);

  // State register with asynchronous active-low reset back to instruction fetch
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= FETCH_ADDR;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; memory states wait on mem_ready, HALT is absorbing
  always_comb begin
    next_state = state;
    case (state)
      FETCH_ADDR: if (bus.run) next_state = FETCH_RD;
      FETCH_RD:   if (bus.mem_ready) next_state = DECODE;
      DECODE: begin
        case (opc)
          OP_STORE:                           next_state = EXEC_WR;
          OP_LOAD, OP_ADD, OP_SUB, OP_XOR:    next_state = EXEC_RD;
          OP_HALT:                            next_state = HALT;
          default:                            next_state = FETCH_ADDR;
        endcase
      end
      EXEC_RD:    if (bus.mem_ready) next_state = FETCH_ADDR;
      EXEC_WR:    if (bus.mem_ready) next_state = FETCH_ADDR;
      HALT:       next_state = HALT;
      default:    next_state = FETCH_ADDR;
    endcase
  end

  // Strobe decode; each state enables at most one sysbus driver
  always_comb begin
    bus.PC_bus   = 1'b0;
    bus.load_PC  = 1'b0;
    bus.INC_PC   = 1'b0;
    bus.load_IR  = 1'b0;
    bus.Addr_bus = 1'b0;
    bus.load_MAR = 1'b0;
    bus.MDR_bus  = 1'b0;
    bus.load_MDR = 1'b0;
    bus.CS       = 1'b0;
    bus.R_NW     = 1'b1;
    bus.ACC_bus  = 1'b0;
    bus.load_ACC = 1'b0;
    bus.ALU_op   = ALU_PASS;
    bus.halted   = 1'b0;
    if (n_reset) begin
      case (state)
        FETCH_ADDR: begin
          if (bus.run) begin
            bus.PC_bus   = 1'b1;
            bus.load_MAR = 1'b1;
            bus.INC_PC   = 1'b1;
          end
        end
        FETCH_RD: begin
          bus.CS = 1'b1;
          if (bus.mem_ready) begin
            bus.MDR_bus = 1'b1;
            bus.load_IR = 1'b1;
          end
        end
        DECODE: begin
          case (opc)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_XOR: begin
              bus.Addr_bus = 1'b1;
              bus.load_MAR = 1'b1;
            end
            OP_BNE: begin
              if (!bus.z_flag) begin
                bus.Addr_bus = 1'b1;
                bus.load_PC  = 1'b1;
              end
            end
            OP_JMP: begin
              bus.Addr_bus = 1'b1;
              bus.load_PC  = 1'b1;
            end
            default: ;
          endcase
        end
        EXEC_RD: begin
          bus.CS     = 1'b1;
          bus.ALU_op = alu_for(opc);
          if (bus.mem_ready) begin
            bus.MDR_bus  = 1'b1;
            bus.load_ACC = 1'b1;
          end
        end
        EXEC_WR: begin
          bus.ACC_bus  = 1'b1;
          bus.load_MDR = 1'b1;
          bus.CS       = 1'b1;
          bus.R_NW     = 1'b0;
        end
        HALT:    bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a directed program table, stall and
// reset corner cases, and randomized instructions expanded by an
// instruction-level model into the expected per-cycle strobe pattern.
module tb_cpu_sequencer;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_BNE   = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef struct packed {
    logic       PC_bus;
    logic       load_PC;
    logic       INC_PC;
    logic       load_IR;
    logic       Addr_bus;
    logic       load_MAR;
    logic       MDR_bus;
    logic       load_MDR;
    logic       CS;
    logic       R_NW;
    logic       ACC_bus;
    logic       load_ACC;
    logic [1:0] ALU_op;
    logic       halted;
  } strobes_t;

  typedef struct {
    logic       run;
    logic [2:0] op;
    logic       z;
    logic       mr;
    strobes_t   exp;
  } vec_t;

  logic clock = 1'b0;
  logic n_reset = 1'b0;

  cpu_sequencer_if #(.OP_W(3)) bus();

  cpu_sequencer #(.WORD_W(8), .OP_W(3)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus.master)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  vec_t q[$];
  vec_t prog[$];

  function automatic strobes_t sampleDut();
    strobes_t s;
    s.PC_bus   = bus.PC_bus;
    s.load_PC  = bus.load_PC;
    s.INC_PC   = bus.INC_PC;
    s.load_IR  = bus.load_IR;
    s.Addr_bus = bus.Addr_bus;
    s.load_MAR = bus.load_MAR;
    s.MDR_bus  = bus.MDR_bus;
    s.load_MDR = bus.load_MDR;
    s.CS       = bus.CS;
    s.R_NW     = bus.R_NW;
    s.ACC_bus  = bus.ACC_bus;
    s.load_ACC = bus.load_ACC;
    s.ALU_op   = bus.ALU_op;
    s.halted   = bus.halted;
    return s;
  endfunction

  function automatic strobes_t quiet();
    strobes_t s = '0;
    s.R_NW = 1'b1;
    return s;
  endfunction

  function automatic logic [1:0] aluCode(input logic [2:0] o);
    case (o)
      OP_ADD:  return 2'b01;
      OP_SUB:  return 2'b10;
      OP_XOR:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic checkOutput(input strobes_t exp, input string name);
    strobes_t got;
    got = sampleDut();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b (PC Ld Inc IR Addr MAR MDRb LdMDR CS RNW ACCb LdACC ALU2 H)",
               name, got, exp);
    end
    checks++;
    if ($countones({got.PC_bus, got.Addr_bus, got.MDR_bus, got.ACC_bus}) > 1) begin
      errors++;
      $display("[TB] FAIL %s bus_exclusive: drivers PC/Addr/MDR/ACC = %b, expected at most one",
               name, {got.PC_bus, got.Addr_bus, got.MDR_bus, got.ACC_bus});
    end
    checks++;
    if ((got.load_MDR && got.R_NW) || (got.MDR_bus && !got.R_NW)) begin
      errors++;
      $display("[TB] FAIL %s rw_consistency: load_MDR=%b MDR_bus=%b R_NW=%b",
               name, got.load_MDR, got.MDR_bus, got.R_NW);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    bus.run       = v.run;
    bus.op        = v.op;
    bus.z_flag    = v.z;
    bus.mem_ready = v.mr;
    @(negedge clock);
    checkOutput(v.exp, name);
    @(posedge clock);
    #1;
  endtask

  task automatic pushVec(input logic run, input logic [2:0] op, input logic z,
                         input logic mr, input strobes_t e);
    vec_t v;
    v.run = run; v.op = op; v.z = z; v.mr = mr; v.exp = e;
    q.push_back(v);
  endtask

  // Instruction-level model: one instruction becomes its expected cycle list.
  // Inputs the sequencer must ignore in a given cycle are randomized.
  task automatic expand(input logic [2:0] o, input logic z, input int fst, input int xst);
    strobes_t e;
    e = quiet(); e.PC_bus = 1'b1; e.INC_PC = 1'b1; e.load_MAR = 1'b1;
    pushVec(1'b1, 3'($urandom), 1'($urandom), 1'($urandom), e);
    for (int i = 0; i < fst; i++) begin
      e = quiet(); e.CS = 1'b1;
      pushVec(1'b1, 3'($urandom), 1'($urandom), 1'b0, e);
    end
    e = quiet(); e.CS = 1'b1; e.MDR_bus = 1'b1; e.load_IR = 1'b1;
    pushVec(1'b1, 3'($urandom), 1'($urandom), 1'b1, e);
    e = quiet();
    case (o)
      OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_XOR: begin
        e.Addr_bus = 1'b1; e.load_MAR = 1'b1;
      end
      OP_BNE: if (!z) begin e.Addr_bus = 1'b1; e.load_PC = 1'b1; end
      OP_JMP: begin e.Addr_bus = 1'b1; e.load_PC = 1'b1; end
      default: ;
    endcase
    pushVec(1'b1, o, z, 1'($urandom), e);
    if (o == OP_STORE) begin
      for (int i = 0; i <= xst; i++) begin
        e = quiet(); e.ACC_bus = 1'b1; e.load_MDR = 1'b1; e.CS = 1'b1; e.R_NW = 1'b0;
        pushVec(1'b1, o, z, (i == xst), e);
      end
    end else if (o == OP_LOAD || o == OP_ADD || o == OP_SUB || o == OP_XOR) begin
      for (int i = 0; i <= xst; i++) begin
        e = quiet(); e.CS = 1'b1; e.ALU_op = aluCode(o);
        if (i == xst) begin e.MDR_bus = 1'b1; e.load_ACC = 1'b1; end
        pushVec(1'b1, o, z, (i == xst), e);
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) pushVec(1'b0, 3'($urandom), 1'($urandom), 1'($urandom), quiet());
  endtask

  task automatic runQueue(input string name);
    for (int i = 0; i < q.size(); i++) applyStimulus(q[i], $sformatf("%s[%0d]", name, i));
    q.delete();
  endtask

  task automatic resetMidCycle(input string name);
    #2 n_reset = 1'b0;
    #1 checkOutput(quiet(), name);
  endtask

  strobes_t fa, frd, decm, decbr, rdld, rdadd, wr, hlt;

  initial begin
    fa    = quiet(); fa.PC_bus = 1'b1; fa.INC_PC = 1'b1; fa.load_MAR = 1'b1;
    frd   = quiet(); frd.CS = 1'b1; frd.MDR_bus = 1'b1; frd.load_IR = 1'b1;
    decm  = quiet(); decm.Addr_bus = 1'b1; decm.load_MAR = 1'b1;
    decbr = quiet(); decbr.Addr_bus = 1'b1; decbr.load_PC = 1'b1;
    rdld  = quiet(); rdld.CS = 1'b1; rdld.MDR_bus = 1'b1; rdld.load_ACC = 1'b1;
    rdadd = rdld;    rdadd.ALU_op = 2'b01;
    wr    = quiet(); wr.ACC_bus = 1'b1; wr.load_MDR = 1'b1; wr.CS = 1'b1; wr.R_NW = 1'b0;
    hlt   = quiet(); hlt.halted = 1'b1;

    // Directed program LOAD 30, ADD 30, STORE 31, BNE 30: 4+4+4+3 cycles
    prog.push_back('{1'b1, OP_LOAD,  1'b0, 1'b1, fa});
    prog.push_back('{1'b1, OP_LOAD,  1'b0, 1'b1, frd});
    prog.push_back('{1'b1, OP_LOAD,  1'b0, 1'b1, decm});
    prog.push_back('{1'b1, OP_LOAD,  1'b0, 1'b1, rdld});
    prog.push_back('{1'b1, OP_ADD,   1'b0, 1'b1, fa});
    prog.push_back('{1'b1, OP_ADD,   1'b0, 1'b1, frd});
    prog.push_back('{1'b1, OP_ADD,   1'b0, 1'b1, decm});
    prog.push_back('{1'b1, OP_ADD,   1'b0, 1'b1, rdadd});
    prog.push_back('{1'b1, OP_STORE, 1'b0, 1'b1, fa});
    prog.push_back('{1'b1, OP_STORE, 1'b0, 1'b1, frd});
    prog.push_back('{1'b1, OP_STORE, 1'b0, 1'b1, decm});
    prog.push_back('{1'b1, OP_STORE, 1'b0, 1'b1, wr});
    prog.push_back('{1'b1, OP_BNE,   1'b0, 1'b1, fa});
    prog.push_back('{1'b1, OP_BNE,   1'b0, 1'b1, frd});
    prog.push_back('{1'b1, OP_BNE,   1'b0, 1'b1, decbr});
    prog.push_back('{1'b1, OP_LOAD,  1'b0, 1'b1, fa});

    bus.run = 1'b1; bus.op = OP_LOAD; bus.z_flag = 1'b0; bus.mem_ready = 1'b1;
    $display("[TB] reset held with run=1");
    repeat (3) begin
      @(negedge clock);
      checkOutput(quiet(), "reset_hold");
    end
    @(posedge clock);
    #1 n_reset = 1'b1;

    $display("[TB] directed program table");
    for (int i = 0; i < prog.size(); i++) applyStimulus(prog[i], $sformatf("prog[%0d]", i));
    // prog ends one cycle into the next fetch; finish that fetch as a LOAD
    q.delete();
    expand(OP_LOAD, 1'b0, 0, 0);
    void'(q.pop_front());
    runQueue("prog_tail");

    $display("[TB] stall, branch and idle sequences");
    expand(OP_LOAD, 1'b0, 2, 1);  runQueue("load_stall");
    expand(OP_BNE,  1'b1, 0, 0);  runQueue("bne_taken_not");
    expand(OP_JMP,  1'b1, 0, 0);  runQueue("jmp_z1");
    expand(OP_JMP,  1'b0, 0, 0);  runQueue("jmp_z0");
    idleCycles(3);                runQueue("idle");

    $display("[TB] randomized instructions");
    for (int n = 0; n < 60; n++) begin
      expand(3'($urandom_range(0, 6)), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
    end
    runQueue("rand");

    $display("[TB] async reset during stalled write");
    expand(OP_STORE, 1'b0, 0, 3);
    for (int i = 0; i < 4; i++) applyStimulus(q[i], $sformatf("store_pre[%0d]", i));
    bus.mem_ready = 1'b0;
    @(negedge clock);
    checkOutput(wr, "store_stalled");
    resetMidCycle("async_reset_wr");
    q.delete();
    @(negedge clock);
    checkOutput(quiet(), "reset_low_again");
    @(posedge clock);
    #1 n_reset = 1'b1;
    idleCycles(3);                runQueue("run_low_after_reset");
    expand(OP_SUB, 1'b1, 1, 0);   runQueue("sub_after_reset");

    $display("[TB] halt");
    expand(OP_HALT, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) pushVec(1'b1, 3'($urandom), 1'($urandom), 1'($urandom), hlt);
    runQueue("halt");
    bus.run = 1'b1;
    @(negedge clock);
    checkOutput(hlt, "halt_hold");
    resetMidCycle("halt_reset");
    @(posedge clock);
    #1 n_reset = 1'b1;
    expand(OP_XOR, 1'b0, 0, 1);   runQueue("resume_xor");
    expand(OP_BNE, 1'b0, 1, 0);   runQueue("resume_bne");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Control-unit FSM for the basic 8-bit accumulator processor. It runs the fetch/decode/execute cycle and drives every shared-sysbus tri-state enable and register load strobe for PC, IR, ACC/ALU and the memory (ROM/RAM MAR/MDR). It takes the IR opcode field, the ACC zero flag and a memory ready handshake, and it guarantees a single sysbus driver per cycle.

Parameters:
WORD_W, 8, sysbus word width
OP_W, 3, opcode field width (address field is WORD_W-OP_W bits)

Ports:
clock  input  1  system clock, rising edge
n_reset  input  1  asynchronous, active-low reset
run  input  1  level; enables instruction fetch
op  input  OP_W  opcode field from IR
z_flag  input  1  ACC==0 flag
mem_ready  input  1  memory access complete this cycle; tie high for zero-wait memory
PC_bus  output  1  PC drives sysbus
load_PC  output  1  PC loads from sysbus
INC_PC  output  1  PC increments
load_IR  output  1  IR loads from sysbus
Addr_bus  output  1  IR address field drives sysbus
load_MAR  output  1  memory MAR loads from sysbus
MDR_bus  output  1  memory MDR drives sysbus
load_MDR  output  1  memory MDR loads from sysbus
CS  output  1  memory chip select
R_NW  output  1  1 = read, 0 = write
ACC_bus  output  1  ACC drives sysbus
load_ACC  output  1  ACC loads ALU result
ALU_op  output  2  00 PASS, 01 ADD, 10 SUB, 11 XOR
halted  output  1  HALT executed

Behaviour:
- Reset: state=FETCH_ADDR. All outputs 0 except R_NW=1. Async reset mid-instruction aborts the instruction. No memory write completes after n_reset falls.
- Opcodes: LOAD 000, STORE 001, ADD 010, SUB 011, BNE 100, XOR 101, JMP 110, HALT 111.
- FETCH_ADDR: run=1 -> PC_bus, load_MAR, INC_PC; go to FETCH_RD. run=0 -> all strobes 0, hold state.
- FETCH_RD: CS=1, R_NW=1. mem_ready=1 -> MDR_bus, load_IR, go to DECODE. mem_ready=0 -> hold state with no bus driver.
- DECODE:
  - LOAD/STORE/ADD/SUB/XOR -> Addr_bus, load_MAR; STORE goes to EXEC_WR, the others to EXEC_RD.
  - BNE: z_flag=0 -> Addr_bus, load_PC. z_flag=1 -> no strobes. Either case -> FETCH_ADDR.
  - JMP -> Addr_bus, load_PC; go to FETCH_ADDR.
  - HALT -> go to HALT.
- EXEC_RD: CS=1, R_NW=1. ALU_op = PASS/ADD/SUB/XOR for LOAD/ADD/SUB/XOR. mem_ready=1 -> MDR_bus, load_ACC, go to FETCH_ADDR. Else hold.
- EXEC_WR: ACC_bus, load_MDR, CS=1, R_NW=0. mem_ready=1 -> go to FETCH_ADDR. Else hold, keeping ACC_bus and load_MDR asserted.
- HALT: halted=1, all other strobes 0. Only n_reset exits; run is ignored.
- op and z_flag are sampled only in DECODE and the EXEC states. IR is stable from DECODE to the end of the instruction.
- Latency at mem_ready=1:
  - LOAD/STORE/ADD/SUB/XOR: 4 cycles.
  - BNE/JMP: 3 cycles.
  - Each mem_ready=0 cycle adds 1 cycle.
- Invariants:
  - At most one of PC_bus, Addr_bus, MDR_bus, ACC_bus is high in any cycle.
  - load_MDR implies R_NW=0.
  - MDR_bus implies R_NW=1.
  - Outputs are combinational from state, op, z_flag and mem_ready; no output glitches on state-only transitions.
- Address-field wrap is a datapath matter; the sequencer is width-agnostic beyond OP_W.

Decomposition:
- Package cpu_pkg holds:
  - opcode_t enum (3-bit encodings above)
  - alu_op_t enum
  - state_t enum: FETCH_ADDR, FETCH_RD, DECODE, EXEC_RD, EXEC_WR, HALT
- opcodes.h is regenerated from cpu_pkg to keep the encodings identical.
- Single module. The state register and the output decode stay together; no sub-module.

Test Plan:
- Reset: hold n_reset=0 with run=1 -> all strobes 0, R_NW=1, halted=0. Release -> FETCH_ADDR asserts PC_bus, load_MAR, INC_PC on the first edge.
- Program LOAD 30, ADD 30, STORE 31, BNE 30 with mem_ready=1, z_flag=0 -> 4+4+4+3 cycles. BNE cycle shows Addr_bus+load_PC. Bus-exclusivity assertion never fires.
- LOAD with mem_ready=0 for 2 cycles in FETCH_RD and 1 cycle in EXEC_RD -> instruction takes 7 cycles. No bus driver while stalled. load_ACC asserts exactly once, with ALU_op=00.
- BNE with z_flag=1 -> no load_PC, 3 cycles, next fetch uses the incremented PC. JMP -> load_PC regardless of z_flag.
- HALT (op=111) -> halted=1 from the cycle after DECODE and stays high for 20 cycles with run=1. n_reset pulse -> halted=0, fetch resumes.
- n_reset asserted during EXEC_WR with mem_ready=0 -> R_NW=1 and CS=0 immediately (asynchronous). run=0 after reset -> holds in FETCH_ADDR with no strobes.
